// File: rtl/leaf_stream_bridge_pkg.sv
// Shared types for the leaf stream bridge: run-control FSM states and FIFO pointer sizing.
package leaf_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } leaf_state_e;

    // One extra pointer bit separates full from empty when the index bits match.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/leaf_stream_bridge_if.sv
// Leaf-side (vld/ack) and operator-side (AXI-stream) buses of the leaf stream bridge.
// Handshake: a word moves when valid and ready/ack are high in the same cycle; valid never
// drops without a transfer and data is held stable while stalled.
interface leaf_stream_bridge_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 4
);
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
    logic [NUM_IN_PORTS-1:0]               vld_interface2user;
    logic [NUM_IN_PORTS-1:0]               ack_user2interface;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata;
    logic [NUM_IN_PORTS-1:0]               in_tvalid;
    logic [NUM_IN_PORTS-1:0]               in_tready;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata;
    logic [NUM_OUT_PORTS-1:0]              out_tvalid;
    logic [NUM_OUT_PORTS-1:0]              out_tready;

    modport slave (
        input  dout_leaf_interface2user, vld_interface2user, ack_interface2user,
        input  in_tready, out_tdata, out_tvalid,
        output ack_user2interface, din_leaf_user2interface, vld_user2interface,
        output in_tdata, in_tvalid, out_tready
    );

    modport master (
        output dout_leaf_interface2user, vld_interface2user, ack_interface2user,
        output in_tready, out_tdata, out_tvalid,
        input  ack_user2interface, din_leaf_user2interface, vld_user2interface,
        input  in_tdata, in_tvalid, out_tready
    );
endinterface

// File: rtl/leaf_stream_bridge_fifo.sv
// Per-channel elastic FIFO: registered storage, no push bypass when full, write side held
// closed until the first clock after reset.
module leaf_stream_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready
);
    localparam int PW = ptr_bits(FIFO_DEPTH);
    localparam int AW = PW - 1;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    alive;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_ready = alive & ~full;
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // alive keeps the accept output low throughout reset, not just the pointers clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            alive <= 1'b1;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Adapter between leaf_interface vld/ack buses and one HLS operator: per-channel FIFOs,
// ap_start run-control FSM with drain detection, and per-channel word counters.
module leaf_stream_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            ap_start,
    leaf_stream_bridge_if.slave             bus,
    output logic                            op_ap_start,
    input  logic                            op_ap_done,
    output logic                            busy,
    output logic                            done_pulse,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]  in_count,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0] out_count,
    output leaf_state_e                     state_dbg
);
    leaf_state_e state;
    logic        start_q;
    logic        run_enter;
    logic        drained;

    logic [NUM_IN_PORTS-1:0]               in_ack;
    logic [NUM_IN_PORTS-1:0]               in_vld;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_data;
    logic [NUM_OUT_PORTS-1:0]              out_rdy;
    logic [NUM_OUT_PORTS-1:0]              out_vld;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_data;

    assign bus.ack_user2interface      = in_ack;
    assign bus.in_tvalid               = in_vld;
    assign bus.in_tdata                = in_data;
    assign bus.out_tready              = out_rdy;
    assign bus.vld_user2interface      = out_vld;
    assign bus.din_leaf_user2interface = out_data;

    assign run_enter = (state == ST_IDLE) && ap_start && !start_q;
    assign drained   = (out_vld == '0) && (bus.out_tvalid == '0);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        logic [CNT_BITS-1:0] cnt;

        leaf_stream_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .wr_data  (bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_valid (bus.vld_interface2user[i]),
            .wr_ready (in_ack[i]),
            .rd_data  (in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_valid (in_vld[i]),
            .rd_ready (bus.in_tready[i])
        );

        // A transfer in the run-entry cycle is the first word of the new run.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) cnt <= '0;
            else           cnt <= (run_enter ? '0 : cnt) + CNT_BITS'(in_vld[i] & bus.in_tready[i]);
        end
        assign in_count[i*CNT_BITS +: CNT_BITS] = cnt;
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        logic [CNT_BITS-1:0] cnt;

        leaf_stream_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .wr_data  (bus.out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_valid (bus.out_tvalid[j]),
            .wr_ready (out_rdy[j]),
            .rd_data  (out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_valid (out_vld[j]),
            .rd_ready (bus.ack_interface2user[j])
        );

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) cnt <= '0;
            else           cnt <= (run_enter ? '0 : cnt) + CNT_BITS'(out_vld[j] & bus.ack_interface2user[j]);
        end
        assign out_count[j*CNT_BITS +: CNT_BITS] = cnt;
    end

    // start_q tracks ap_start in every state so a level held through DONE cannot retrigger.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            op_ap_start <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            start_q    <= ap_start;
            done_pulse <= 1'b0;
            case (state)
                ST_IDLE: if (run_enter) begin
                    state       <= ST_RUN;
                    op_ap_start <= 1'b1;
                end
                ST_RUN: if (op_ap_done) begin
                    state       <= ST_DRAIN;
                    op_ap_start <= 1'b0;
                end
                ST_DRAIN: if (drained) begin
                    state      <= ST_DONE;
                    done_pulse <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Self-checking bench for leaf_stream_bridge: directed scenarios plus randomized streams
// compared against an in-order queue model and transfer-count model.
module tb_leaf_stream_bridge;
    import leaf_bridge_pkg::*;

    localparam int PW    = 32;
    localparam int NI    = 2;
    localparam int NO    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic ap_start;
    logic op_ap_start;
    logic op_ap_done;
    logic busy;
    logic done_pulse;
    logic [NI*CW-1:0] in_count;
    logic [NO*CW-1:0] out_count;
    leaf_state_e state_dbg;

    leaf_stream_bridge_if #(.PAYLOAD_BITS(PW), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

    leaf_stream_bridge #(
        .PAYLOAD_BITS(PW), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
        .FIFO_DEPTH(DEPTH), .CNT_BITS(CW)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .bus         (bus),
        .op_ap_start (op_ap_start),
        .op_ap_done  (op_ap_done),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .in_count    (in_count),
        .out_count   (out_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int m_in_cnt[NI];
    int m_out_cnt[NO];
    int n_cmp = 0;
    int n_err = 0;
    int first_push_cyc;
    int first_pop_cyc;
    int block_at;

    // ---------------- driver tasks ----------------
    // Leaf sends exp_q on input channel ch; operator side pulls (always or randomly).
    task automatic xfer_in(input int ch, input int n, input bit rnd);
        int sent, cyc;
        bit on, leaf_fire;
        sent = 0; cyc = 0; on = 0;
        got_q.delete(); first_push_cyc = -1; first_pop_cyc = -1;
        while (got_q.size() < n && cyc < 400) begin
            if (!on && sent < n && (!rnd || $urandom_range(0, 2) != 0)) on = 1;
            bus.vld_interface2user[ch] = on;
            if (sent < n) bus.dout_leaf_interface2user[ch*PW +: PW] = exp_q[sent];
            bus.in_tready[ch] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge ap_clk);
            leaf_fire = on && bus.ack_user2interface[ch];
            if (leaf_fire && first_push_cyc < 0) first_push_cyc = cyc;
            if (bus.in_tvalid[ch] && bus.in_tready[ch]) begin
                got_q.push_back(bus.in_tdata[ch*PW +: PW]);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            tick();
            if (leaf_fire) begin sent++; on = 0; end
            cyc++;
        end
        bus.vld_interface2user[ch] = 1'b0;
        bus.in_tready[ch] = 1'b0;
    endtask

    // Operator sends exp_q on output channel ch; leaf ack held low for `hold` cycles.
    task automatic xfer_out(input int ch, input int n, input int hold, input bit rnd);
        int sent, cyc;
        bit on, op_fire;
        sent = 0; cyc = 0; on = 0;
        got_q.delete(); block_at = -1;
        while (got_q.size() < n && cyc < 400) begin
            if (!on && sent < n && (!rnd || $urandom_range(0, 2) != 0)) on = 1;
            bus.out_tvalid[ch] = on;
            if (sent < n) bus.out_tdata[ch*PW +: PW] = exp_q[sent];
            bus.ack_interface2user[ch] = (cyc < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            @(negedge ap_clk);
            op_fire = on && bus.out_tready[ch];
            if (on && !bus.out_tready[ch] && block_at < 0) block_at = sent;
            if (bus.vld_user2interface[ch] && bus.ack_interface2user[ch])
                got_q.push_back(bus.din_leaf_user2interface[ch*PW +: PW]);
            tick();
            if (op_fire) begin sent++; on = 0; end
            cyc++;
        end
        bus.out_tvalid[ch] = 1'b0;
        bus.ack_interface2user[ch] = 1'b0;
    endtask

    // Leaf pushes all of exp_q into input channel ch without touching in_tready.
    task automatic leaf_push(input int ch);
        int sent, cyc;
        bit fire;
        sent = 0; cyc = 0;
        while (sent < exp_q.size() && cyc < 50) begin
            bus.vld_interface2user[ch] = 1'b1;
            bus.dout_leaf_interface2user[ch*PW +: PW] = exp_q[sent];
            @(negedge ap_clk);
            fire = bus.ack_user2interface[ch];
            tick();
            if (fire) sent++;
            cyc++;
        end
        bus.vld_interface2user[ch] = 1'b0;
    endtask

    // Operator pushes all of exp_q into output channel ch without touching the leaf ack.
    task automatic op_push(input int ch);
        int sent, cyc;
        bit fire;
        sent = 0; cyc = 0;
        while (sent < exp_q.size() && cyc < 50) begin
            bus.out_tvalid[ch] = 1'b1;
            bus.out_tdata[ch*PW +: PW] = exp_q[sent];
            @(negedge ap_clk);
            fire = bus.out_tready[ch];
            tick();
            if (fire) sent++;
            cyc++;
        end
        bus.out_tvalid[ch] = 1'b0;
    endtask

    task automatic fill_exp(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(PW'($urandom()));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; op_ap_done = 1'b0;
        bus.dout_leaf_interface2user = '0; bus.vld_interface2user = '1;
        bus.ack_interface2user = '0; bus.in_tready = '0;
        bus.out_tdata = '0; bus.out_tvalid = '0;
        repeat (3) tick();
        n_cmp++; if (bus.ack_user2interface !== '0) begin n_err++; $display("FAIL reset_ack got=%h exp=0", bus.ack_user2interface); end
        n_cmp++; if (bus.in_tvalid !== '0) begin n_err++; $display("FAIL reset_in_tvalid got=%h exp=0", bus.in_tvalid); end
        n_cmp++; if (bus.vld_user2interface !== '0) begin n_err++; $display("FAIL reset_vld_out got=%h exp=0", bus.vld_user2interface); end
        n_cmp++; if (bus.out_tready !== '0) begin n_err++; $display("FAIL reset_out_tready got=%h exp=0", bus.out_tready); end
        n_cmp++; if (busy !== 1'b0 || op_ap_start !== 1'b0 || done_pulse !== 1'b0) begin n_err++; $display("FAIL reset_ctrl got=%b%b%b exp=000", busy, op_ap_start, done_pulse); end
        n_cmp++; if (in_count !== '0 || out_count !== '0) begin n_err++; $display("FAIL reset_counts got=%h/%h exp=0", in_count, out_count); end
        n_cmp++; if (bus.in_tdata !== '0 || bus.din_leaf_user2interface !== '0) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0", bus.in_tdata, bus.din_leaf_user2interface); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
        bus.vld_interface2user = '0;
        ap_rst_n = 1'b1;
        repeat (2) tick();
        n_cmp++; if (bus.ack_user2interface !== '1 || bus.out_tready !== '1) begin n_err++; $display("FAIL post_reset_ready got=%h/%h exp=all1", bus.ack_user2interface, bus.out_tready); end
        for (int i = 0; i < NI; i++) m_in_cnt[i] = 0;
        for (int j = 0; j < NO; j++) m_out_cnt[j] = 0;
    endtask

    task automatic test_stream();
        exp_q.delete();
        for (int k = 1; k <= 8; k++) exp_q.push_back(PW'(k));
        xfer_in(0, 8, 1'b0);
        m_in_cnt[0] += 8;
        n_cmp++; if (got_q.size() != 8) begin n_err++; $display("FAIL stream_len got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stream_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (first_pop_cyc - first_push_cyc != 1) begin n_err++; $display("FAIL stream_latency got=%0d exp=1", first_pop_cyc - first_push_cyc); end
        n_cmp++; if (in_count[0 +: CW] !== CW'(m_in_cnt[0])) begin n_err++; $display("FAIL stream_in_count got=%0d exp=%0d", in_count[0 +: CW], m_in_cnt[0]); end
    endtask

    task automatic test_backpressure();
        fill_exp(5);
        xfer_out(2, 5, 12, 1'b0);
        m_out_cnt[2] += 5;
        n_cmp++; if (block_at != DEPTH) begin n_err++; $display("FAIL bp_block_at got=%0d exp=%0d", block_at, DEPTH); end
        n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL bp_len got=%0d exp=5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (out_count[2*CW +: CW] !== CW'(m_out_cnt[2])) begin n_err++; $display("FAIL bp_out_count got=%0d exp=%0d", out_count[2*CW +: CW], m_out_cnt[2]); end
    endtask

    task automatic test_full_push_pop();
        logic [PW-1:0] extra;
        int cyc;
        fill_exp(DEPTH);
        bus.in_tready[1] = 1'b0;
        leaf_push(1);
        m_in_cnt[1] += DEPTH;
        @(negedge ap_clk);
        n_cmp++; if (bus.ack_user2interface[1] !== 1'b0) begin n_err++; $display("FAIL full_ack got=%b exp=0", bus.ack_user2interface[1]); end
        tick();
        extra = ~exp_q[0];
        bus.vld_interface2user[1] = 1'b1;
        bus.dout_leaf_interface2user[PW +: PW] = extra;
        bus.in_tready[1] = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (bus.ack_user2interface[1] !== 1'b0 || bus.in_tdata[PW +: PW] !== exp_q[0]) begin n_err++; $display("FAIL full_pushpop got=ack%b/%h exp=ack0/%h", bus.ack_user2interface[1], bus.in_tdata[PW +: PW], exp_q[0]); end
        tick();
        bus.vld_interface2user[1] = 1'b0;
        bus.in_tready[1] = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if (bus.ack_user2interface[1] !== 1'b1) begin n_err++; $display("FAIL after_pop_ack got=%b exp=1", bus.ack_user2interface[1]); end
        tick();
        got_q.delete();
        bus.in_tready[1] = 1'b1;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge ap_clk);
            if (bus.in_tvalid[1]) got_q.push_back(bus.in_tdata[PW +: PW]);
            tick();
        end
        bus.in_tready[1] = 1'b0;
        n_cmp++; if (got_q.size() != DEPTH - 1) begin n_err++; $display("FAIL full_occupancy got=%0d exp=%0d", got_q.size(), DEPTH - 1); end
        for (int k = 0; k < got_q.size() && k < DEPTH - 1; k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k+1]) begin n_err++; $display("FAIL full_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k+1]); end
        end
        n_cmp++; if (in_count[CW +: CW] !== CW'(m_in_cnt[1])) begin n_err++; $display("FAIL full_in_count got=%0d exp=%0d", in_count[CW +: CW], m_in_cnt[1]); end
    endtask

    task automatic test_random();
        int ch, n;
        for (int it = 0; it < 4; it++) begin
            ch = $urandom_range(0, NI - 1);
            n = $urandom_range(3, 12);
            fill_exp(n);
            xfer_in(ch, n, 1'b1);
            m_in_cnt[ch] += n;
            n_cmp++; if (got_q.size() != n) begin n_err++; $display("FAIL rnd_in_len ch%0d got=%0d exp=%0d", ch, got_q.size(), n); end
            for (int k = 0; k < n && k < got_q.size(); k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rnd_in_word ch%0d[%0d] got=%h exp=%h", ch, k, got_q[k], exp_q[k]); end
            end
            n_cmp++; if (in_count[ch*CW +: CW] !== CW'(m_in_cnt[ch])) begin n_err++; $display("FAIL rnd_in_count ch%0d got=%0d exp=%0d", ch, in_count[ch*CW +: CW], m_in_cnt[ch]); end
        end
        for (int it = 0; it < 4; it++) begin
            ch = $urandom_range(0, NO - 1);
            n = $urandom_range(3, 12);
            fill_exp(n);
            xfer_out(ch, n, $urandom_range(0, 6), 1'b1);
            m_out_cnt[ch] += n;
            n_cmp++; if (got_q.size() != n) begin n_err++; $display("FAIL rnd_out_len ch%0d got=%0d exp=%0d", ch, got_q.size(), n); end
            for (int k = 0; k < n && k < got_q.size(); k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rnd_out_word ch%0d[%0d] got=%h exp=%h", ch, k, got_q[k], exp_q[k]); end
            end
            n_cmp++; if (out_count[ch*CW +: CW] !== CW'(m_out_cnt[ch])) begin n_err++; $display("FAIL rnd_out_count ch%0d got=%0d exp=%0d", ch, out_count[ch*CW +: CW], m_out_cnt[ch]); end
        end
    endtask

    task automatic test_run_control();
        int done_cnt, got_at_done, cyc;
        ap_start = 1'b0;
        repeat (2) tick();
        ap_start = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) m_in_cnt[i] = 0;
        for (int j = 0; j < NO; j++) m_out_cnt[j] = 0;
        n_cmp++; if (op_ap_start !== 1'b1 || busy !== 1'b1 || state_dbg !== ST_RUN) begin n_err++; $display("FAIL run_enter got=start%b busy%b st%0d exp=1/1/%0d", op_ap_start, busy, state_dbg, ST_RUN); end
        n_cmp++; if (in_count !== '0 || out_count !== '0) begin n_err++; $display("FAIL run_clear got=%h/%h exp=0", in_count, out_count); end
        fill_exp(2);
        op_push(3);
        op_ap_done = 1'b1;
        tick();
        op_ap_done = 1'b0;
        n_cmp++; if (op_ap_start !== 1'b0 || state_dbg !== ST_DRAIN || busy !== 1'b1) begin n_err++; $display("FAIL drain_enter got=start%b st%0d exp=0/%0d", op_ap_start, state_dbg, ST_DRAIN); end
        repeat (3) tick();
        n_cmp++; if (state_dbg !== ST_DRAIN || done_pulse !== 1'b0) begin n_err++; $display("FAIL drain_hold got=st%0d done%b exp=%0d/0", state_dbg, done_pulse, ST_DRAIN); end
        got_q.delete(); done_cnt = 0; got_at_done = -1;
        bus.ack_interface2user[3] = 1'b1;
        for (cyc = 0; cyc < 12; cyc++) begin
            @(negedge ap_clk);
            if (bus.vld_user2interface[3]) got_q.push_back(bus.din_leaf_user2interface[3*PW +: PW]);
            if (done_pulse) begin done_cnt++; if (got_at_done < 0) got_at_done = got_q.size(); end
            tick();
        end
        bus.ack_interface2user[3] = 1'b0;
        m_out_cnt[3] += 2;
        n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL drain_len got=%0d exp=2", got_q.size()); end
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL drain_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL done_pulse_len got=%0d exp=1", done_cnt); end
        n_cmp++; if (got_at_done != 2) begin n_err++; $display("FAIL done_before_drain got=%0d exp=2", got_at_done); end
        n_cmp++; if (out_count[3*CW +: CW] !== CW'(m_out_cnt[3])) begin n_err++; $display("FAIL run_out_count got=%0d exp=%0d", out_count[3*CW +: CW], m_out_cnt[3]); end
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b0 || op_ap_start !== 1'b0 || state_dbg !== ST_IDLE) begin n_err++; $display("FAIL no_retrigger got=busy%b start%b exp=0/0", busy, op_ap_start); end
        op_ap_done = 1'b1;
        tick();
        op_ap_done = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_done_ignored got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int cyc, done_cnt;
        ap_start = 1'b0;
        tick();
        ap_start = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || op_ap_start !== 1'b1) begin n_err++; $display("FAIL restart got=busy%b start%b exp=1/1", busy, op_ap_start); end
        op_ap_done = 1'b1;
        tick();
        op_ap_done = 1'b0;
        done_cnt = 0;
        for (cyc = 0; cyc < 6; cyc++) begin
            @(negedge ap_clk);
            if (done_pulse) done_cnt++;
            tick();
        end
        n_cmp++; if (done_cnt != 1 || busy !== 1'b0) begin n_err++; $display("FAIL empty_run got=pulses%0d busy%b exp=1/0", done_cnt, busy); end
        ap_start = 1'b0;
        tick();
    endtask

    task automatic test_midrun_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        n_cmp++; if (state_dbg !== ST_RUN) begin n_err++; $display("FAIL mid_run_enter got=%0d exp=%0d", state_dbg, ST_RUN); end
        fill_exp(2);
        leaf_push(0);
        fill_exp(2);
        op_push(1);
        @(negedge ap_clk);
        n_cmp++; if (bus.in_tvalid[0] !== 1'b1 || bus.vld_user2interface[1] !== 1'b1) begin n_err++; $display("FAIL mid_half_full got=%b/%b exp=1/1", bus.in_tvalid[0], bus.vld_user2interface[1]); end
        tick();
        ap_rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_tvalid !== '0 || bus.vld_user2interface !== '0) begin n_err++; $display("FAIL mid_rst_valid got=%h/%h exp=0", bus.in_tvalid, bus.vld_user2interface); end
        n_cmp++; if (bus.ack_user2interface !== '0 || bus.out_tready !== '0) begin n_err++; $display("FAIL mid_rst_ready got=%h/%h exp=0", bus.ack_user2interface, bus.out_tready); end
        n_cmp++; if (busy !== 1'b0 || op_ap_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl got=%b%b exp=00", busy, op_ap_start); end
        repeat (2) tick();
        ap_rst_n = 1'b1;
        bus.in_tready = '1;
        bus.ack_interface2user = '1;
        repeat (3) tick();
        @(negedge ap_clk);
        n_cmp++; if (bus.in_tvalid !== '0 || bus.vld_user2interface !== '0) begin n_err++; $display("FAIL mid_post_empty got=%h/%h exp=0", bus.in_tvalid, bus.vld_user2interface); end
        n_cmp++; if (state_dbg !== ST_IDLE || in_count !== '0 || out_count !== '0) begin n_err++; $display("FAIL mid_post_state got=st%0d cnt=%h/%h exp=%0d/0/0", state_dbg, in_count, out_count, ST_IDLE); end
        n_cmp++; if (bus.ack_user2interface !== '1) begin n_err++; $display("FAIL mid_post_ack got=%h exp=all1", bus.ack_user2interface); end
        tick();
        bus.in_tready = '0;
        bus.ack_interface2user = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_random();
        test_run_control();
        test_back_to_back();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
